// File: rtl/core_run_pkg.sv
// ----------------------------------------------------------------------------
// core_run_pkg
// Shared types and parameter-legality helper for core_run_sequencer.
//   run_state_e   : sequencer FSM state encoding
//   params_legal(): elaboration-time range check for the sequencer parameters
// ----------------------------------------------------------------------------
package core_run_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } run_state_e;

   // True when every sequencer parameter lies in its supported range.
   function automatic bit params_legal(input int unsigned reset_cycles,
                                       input int unsigned max_cycles,
                                       input int unsigned stable_cycles,
                                       input int unsigned count_width);
      longint unsigned count_limit;
      count_limit = (count_width >= 63) ? 64'hFFFF_FFFF_FFFF_FFFF
                                        : (64'd1 << count_width);
      return (reset_cycles >= 1) && (stable_cycles >= 2) && (max_cycles >= 1) &&
             (count_width >= 1) && (64'(max_cycles) < count_limit);
   endfunction

endpackage : core_run_pkg

// File: rtl/core_run_sequencer_stability.sv
// ----------------------------------------------------------------------------
// result_stability_detector
// Tracks how many consecutive identical Result samples have been seen and
// flags the sample on which that run length reaches STABLE_CYCLES.
//   clk_i         : clock, rising edge
//   reset_i       : synchronous active-high reset
//   clear_i       : start of a new run; forgets history
//   sample_i      : take a Result sample this cycle
//   result_i      : Core Result bus
//   last_result_o : most recent sampled Result (registered)
//   settled_c_o   : this sample brings the run length to STABLE_CYCLES
// ----------------------------------------------------------------------------
module result_stability_detector #(
   parameter int unsigned DATA_WIDTH    = 18,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  clear_i,
   input  logic                  sample_i,
   input  logic [DATA_WIDTH-1:0] result_i,
   output logic [DATA_WIDTH-1:0] last_result_o,
   output logic                  settled_c_o
);

   localparam int unsigned RUN_W = $clog2(STABLE_CYCLES + 1);

   logic [RUN_W-1:0]      run_len_q, run_len_d;
   logic [DATA_WIDTH-1:0] last_q, last_d;

   // Run length 0 marks "no sample yet", so the first sample always restarts at 1.
   always_comb begin
      run_len_d = run_len_q;
      last_d    = last_q;
      if (clear_i) begin
         run_len_d = '0;
         last_d    = '0;
      end else if (sample_i) begin
         last_d = result_i;
         if ((run_len_q == '0) || (result_i != last_q)) begin
            run_len_d = RUN_W'(1);
         end else if (run_len_q != RUN_W'(STABLE_CYCLES)) begin
            run_len_d = run_len_q + RUN_W'(1);
         end
      end
   end

   assign settled_c_o = sample_i && !clear_i && (run_len_d == RUN_W'(STABLE_CYCLES));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         run_len_q <= '0;
         last_q    <= '0;
      end else begin
         run_len_q <= run_len_d;
         last_q    <= last_d;
      end
   end

   assign last_result_o = last_q;

endmodule : result_stability_detector

// File: rtl/core_run_sequencer.sv
// ----------------------------------------------------------------------------
// core_run_sequencer
// Holds the Core in reset, releases it for a bounded run, waits for Result to
// settle, then reports completion, cycle count and pass/fail against Expected.
//   CLK         : clock, rising edge
//   Reset       : synchronous active-high block reset
//   Start       : launch a run (honoured in IDLE or DONE only)
//   Result      : Core output, sampled every RUN cycle
//   Expected    : golden value, compared on the terminating sample
//   Core_Reset  : Core reset drive (low only in RUN)
//   Busy        : HOLD or RUN
//   Done        : run finished
//   Pass        : settled Result matched Expected (valid with Done)
//   Timeout     : budget ran out before settling (valid with Done)
//   Cycle_Count : RUN samples in the current/last run
//   Last_Result : most recent sampled Result
// ----------------------------------------------------------------------------
module core_run_sequencer
   import core_run_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 18,
   parameter int unsigned RESET_CYCLES  = 1,
   parameter int unsigned MAX_CYCLES    = 100,
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned COUNT_WIDTH   = 16
) (
   input  logic                   CLK,
   input  logic                   Reset,
   input  logic                   Start,
   input  logic [DATA_WIDTH-1:0]  Result,
   input  logic [DATA_WIDTH-1:0]  Expected,
   output logic                   Core_Reset,
   output logic                   Busy,
   output logic                   Done,
   output logic                   Pass,
   output logic                   Timeout,
   output logic [COUNT_WIDTH-1:0] Cycle_Count,
   output logic [DATA_WIDTH-1:0]  Last_Result
);

   localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   if (!params_legal(RESET_CYCLES, MAX_CYCLES, STABLE_CYCLES, COUNT_WIDTH)) begin : g_param_check
      $error("core_run_sequencer: parameter out of range");
   end

   run_state_e             state_q, state_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic [COUNT_WIDTH-1:0] cycle_q, cycle_d;
   logic                   pass_q, pass_d;
   logic                   timeout_q, timeout_d;
   logic                   core_reset_q, core_reset_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   det_clear_c, det_sample_c, settled_c;

   result_stability_detector #(
      .DATA_WIDTH    (DATA_WIDTH),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_stability (
      .clk_i         (CLK),
      .reset_i       (Reset),
      .clear_i       (det_clear_c),
      .sample_i      (det_sample_c),
      .result_i      (Result),
      .last_result_o (Last_Result),
      .settled_c_o   (settled_c)
   );

   // Next-state and next-output logic; settle takes priority over timeout.
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      cycle_d      = cycle_q;
      pass_d       = pass_q;
      timeout_d    = timeout_q;
      det_clear_c  = 1'b0;
      det_sample_c = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (Start) begin
               state_d     = HOLD;
               hold_d      = '0;
               cycle_d     = '0;
               pass_d      = 1'b0;
               timeout_d   = 1'b0;
               det_clear_c = 1'b1;
            end
         end
         HOLD: begin
            if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
               state_d = RUN;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         RUN: begin
            det_sample_c = 1'b1;
            cycle_d      = cycle_q + COUNT_WIDTH'(1);
            if (settled_c) begin
               state_d   = DONE;
               pass_d    = (Result == Expected);
               timeout_d = 1'b0;
            end else if (cycle_d == COUNT_WIDTH'(MAX_CYCLES)) begin
               state_d   = DONE;
               pass_d    = 1'b0;
               timeout_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      core_reset_d = (state_d != RUN);
      busy_d       = (state_d == HOLD) || (state_d == RUN);
      done_d       = (state_d == DONE);
   end

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q      <= IDLE;
         hold_q       <= '0;
         cycle_q      <= '0;
         pass_q       <= 1'b0;
         timeout_q    <= 1'b0;
         core_reset_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         cycle_q      <= cycle_d;
         pass_q       <= pass_d;
         timeout_q    <= timeout_d;
         core_reset_q <= core_reset_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign Core_Reset  = core_reset_q;
   assign Busy        = busy_q;
   assign Done        = done_q;
   assign Pass        = pass_q;
   assign Timeout     = timeout_q;
   assign Cycle_Count = cycle_q;

endmodule : core_run_sequencer

// File: tb/tb_core_run_sequencer.sv
// ----------------------------------------------------------------------------
// tb_core_run_sequencer
// Three sequencer instances (defaults, MAX_CYCLES=4, RESET_CYCLES=3).
// Stimulus pushes the expected completion record per run; a negedge monitor
// pops it whenever an instance raises Done and compares the report.
// ----------------------------------------------------------------------------
module tb_core_run_sequencer;

   localparam int unsigned DW = 18;
   localparam int unsigned CW = 16;

   typedef struct packed {
      logic [CW-1:0] cnt;
      logic          pass;
      logic          tmo;
      logic [DW-1:0] last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_a      [3];
   logic          start_a    [3];
   logic [DW-1:0] result_a   [3];
   logic [DW-1:0] expected_a [3];

   wire           core_reset_w [3];
   wire           busy_w       [3];
   wire           done_w       [3];
   wire           pass_w       [3];
   wire           tmo_w        [3];
   wire  [CW-1:0] cnt_w        [3];
   wire  [DW-1:0] last_w       [3];

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int n_checks = 0;
   int n_pass   = 0;
   logic done_prev [3] = '{1'b0, 1'b0, 1'b0};

   always #5 clk = ~clk;

   core_run_sequencer #(.DATA_WIDTH(DW), .RESET_CYCLES(1), .MAX_CYCLES(100),
                        .STABLE_CYCLES(4), .COUNT_WIDTH(CW)) u_dut0 (
      .CLK(clk), .Reset(rst_a[0]), .Start(start_a[0]), .Result(result_a[0]),
      .Expected(expected_a[0]), .Core_Reset(core_reset_w[0]), .Busy(busy_w[0]),
      .Done(done_w[0]), .Pass(pass_w[0]), .Timeout(tmo_w[0]),
      .Cycle_Count(cnt_w[0]), .Last_Result(last_w[0]));

   core_run_sequencer #(.DATA_WIDTH(DW), .RESET_CYCLES(1), .MAX_CYCLES(4),
                        .STABLE_CYCLES(4), .COUNT_WIDTH(CW)) u_dut1 (
      .CLK(clk), .Reset(rst_a[1]), .Start(start_a[1]), .Result(result_a[1]),
      .Expected(expected_a[1]), .Core_Reset(core_reset_w[1]), .Busy(busy_w[1]),
      .Done(done_w[1]), .Pass(pass_w[1]), .Timeout(tmo_w[1]),
      .Cycle_Count(cnt_w[1]), .Last_Result(last_w[1]));

   core_run_sequencer #(.DATA_WIDTH(DW), .RESET_CYCLES(3), .MAX_CYCLES(100),
                        .STABLE_CYCLES(4), .COUNT_WIDTH(CW)) u_dut2 (
      .CLK(clk), .Reset(rst_a[2]), .Start(start_a[2]), .Result(result_a[2]),
      .Expected(expected_a[2]), .Core_Reset(core_reset_w[2]), .Busy(busy_w[2]),
      .Done(done_w[2]), .Pass(pass_w[2]), .Timeout(tmo_w[2]),
      .Cycle_Count(cnt_w[2]), .Last_Result(last_w[2]));

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d: got 0x%0h, want 0x%0h", name, idx, act, exp);
   endtask

   task automatic push_exp(input int idx, input exp_t e);
      case (idx)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Monitor: on each rising Done, pop the expected record and compare.
   always @(negedge clk) begin
      exp_t e;
      bit   have;
      for (int i = 0; i < 3; i++) begin
         if (done_w[i] && !done_prev[i]) begin
            have = 1'b0;
            e    = '0;
            case (i)
               0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
               1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
               default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            check("done_expected", i, 32'(have), 32'd1);
            if (have) begin
               check("cycle_count", i, 32'(cnt_w[i]), 32'(e.cnt));
               check("pass", i, 32'(pass_w[i]), 32'(e.pass));
               check("timeout", i, 32'(tmo_w[i]), 32'(e.tmo));
               check("last_result", i, 32'(last_w[i]), 32'(e.last));
               check("done_busy", i, 32'(busy_w[i]), 32'd0);
               check("done_core_reset", i, 32'(core_reset_w[i]), 32'd1);
            end
         end
         done_prev[i] = done_w[i];
      end
   end

   // Pulse Start, check the HOLD window, then drive n RUN samples.
   // Sample s gets: toggle ? (odd a / even b) : (s < sw ? a : b).
   task automatic run_seq(input int idx, input int r, input int n, input bit toggle,
                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int sw, input int start_at);
      start_a[idx] = 1'b1;
      @(posedge clk); #1;
      start_a[idx] = 1'b0;
      check("start_cnt_clear", idx, 32'(cnt_w[idx]), 32'd0);
      check("start_last_clear", idx, 32'(last_w[idx]), 32'd0);
      check("start_done_low", idx, 32'(done_w[idx]), 32'd0);
      check("start_flags_clear", idx, 32'({pass_w[idx], tmo_w[idx]}), 32'd0);
      for (int h = 0; h < r; h++) begin
         check("hold_core_reset", idx, 32'(core_reset_w[idx]), 32'd1);
         check("hold_busy", idx, 32'(busy_w[idx]), 32'd1);
         @(posedge clk); #1;
      end
      check("run_core_reset", idx, 32'(core_reset_w[idx]), 32'd0);
      for (int s = 1; s <= n; s++) begin
         if (toggle) result_a[idx] = (s % 2 == 1) ? a : b;
         else        result_a[idx] = (s < sw) ? a : b;
         start_a[idx] = (s == start_at);
         @(posedge clk); #1;
         start_a[idx] = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_a[i] = 1'b1; start_a[i] = 1'b0; result_a[i] = '0; expected_a[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         rst_a[i] = 1'b0;
         check("rst_core_reset", i, 32'(core_reset_w[i]), 32'd1);
         check("rst_busy", i, 32'(busy_w[i]), 32'd0);
         check("rst_done", i, 32'(done_w[i]), 32'd0);
         check("rst_pass", i, 32'(pass_w[i]), 32'd0);
         check("rst_timeout", i, 32'(tmo_w[i]), 32'd0);
         check("rst_cnt", i, 32'(cnt_w[i]), 32'd0);
         check("rst_last", i, 32'(last_w[i]), 32'd0);
      end

      // Constant 5 vs 5: settles after 4 samples, passes; then DONE holds.
      expected_a[0] = 18'h00005;
      push_exp(0, '{cnt: 16'd4, pass: 1'b1, tmo: 1'b0, last: 18'h00005});
      run_seq(0, 1, 4, 1'b0, 18'h00005, 18'h00005, 1, 0);
      repeat (3) @(posedge clk);
      #1;
      check("hold_done", 0, 32'(done_w[0]), 32'd1);
      check("hold_cnt", 0, 32'(cnt_w[0]), 32'd4);
      check("hold_pass", 0, 32'(pass_w[0]), 32'd1);
      check("hold_core_reset", 0, 32'(core_reset_w[0]), 32'd1);

      // Toggling 1,2,...: never settles, times out at 100 with last value 2.
      expected_a[0] = 18'h00001;
      push_exp(0, '{cnt: 16'd100, pass: 1'b0, tmo: 1'b1, last: 18'h00002});
      run_seq(0, 1, 100, 1'b1, 18'h00001, 18'h00002, 0, 0);

      // Full-width mismatch by one bit: settles but fails.
      expected_a[0] = 18'h3FFFE;
      push_exp(0, '{cnt: 16'd4, pass: 1'b0, tmo: 1'b0, last: 18'h3FFFF});
      run_seq(0, 1, 4, 1'b0, 18'h3FFFF, 18'h3FFFF, 1, 0);

      // Abort with Reset on RUN sample 2; no Done may follow.
      expected_a[0] = 18'h00007;
      run_seq(0, 1, 1, 1'b0, 18'h00007, 18'h00007, 1, 0);
      result_a[0] = 18'h00007;
      rst_a[0] = 1'b1;
      @(posedge clk); #1;
      rst_a[0] = 1'b0;
      check("abort_core_reset", 0, 32'(core_reset_w[0]), 32'd1);
      check("abort_busy", 0, 32'(busy_w[0]), 32'd0);
      check("abort_done", 0, 32'(done_w[0]), 32'd0);
      check("abort_cnt", 0, 32'(cnt_w[0]), 32'd0);
      check("abort_last", 0, 32'(last_w[0]), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      check("abort_still_idle", 0, 32'({done_w[0], busy_w[0]}), 32'd0);
      expected_a[0] = 18'h00009;
      push_exp(0, '{cnt: 16'd4, pass: 1'b1, tmo: 1'b0, last: 18'h00009});
      run_seq(0, 1, 4, 1'b0, 18'h00009, 18'h00009, 1, 0);

      // MAX_CYCLES=4: settle and budget coincide; settle wins.
      expected_a[1] = 18'h0002A;
      push_exp(1, '{cnt: 16'd4, pass: 1'b1, tmo: 1'b0, last: 18'h0002A});
      run_seq(1, 1, 4, 1'b0, 18'h0002A, 18'h0002A, 1, 0);
      // 1,1,1,2: last sample breaks the run, so the budget expires.
      expected_a[1] = 18'h00002;
      push_exp(1, '{cnt: 16'd4, pass: 1'b0, tmo: 1'b1, last: 18'h00002});
      run_seq(1, 1, 4, 1'b0, 18'h00001, 18'h00002, 4, 0);

      // RESET_CYCLES=3, Start pulses during RUN ignored, restart from DONE.
      expected_a[2] = 18'h00003;
      push_exp(2, '{cnt: 16'd4, pass: 1'b1, tmo: 1'b0, last: 18'h00003});
      run_seq(2, 3, 4, 1'b0, 18'h00003, 18'h00003, 1, 2);
      repeat (2) @(posedge clk);
      #1;
      expected_a[2] = 18'h00006;
      push_exp(2, '{cnt: 16'd5, pass: 1'b1, tmo: 1'b0, last: 18'h00006});
      run_seq(2, 3, 5, 1'b0, 18'h00005, 18'h00006, 2, 3);

      repeat (4) @(posedge clk);
      #1;
      check("q0_drained", 0, 32'(q0.size()), 32'd0);
      check("q1_drained", 1, 32'(q1.size()), 32'd0);
      check("q2_drained", 2, 32'(q2.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_core_run_sequencer
